awg_seq_ctrl: RTL and testbench

AWG_SEQ_CTRL -- requirements
Module: awg_seq_ctrl

---
 rtl/awg_seq_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_awg_seq_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// awg_seq_ctrl
//
// Sequencer for an arbitrary waveform generator. A phase accumulator advances
// by a configurable frequency step while the sequencer runs. Its top 14 bits,
// offset by a phase word, form the phase index driven to the generators.
// A new configuration is staged in a shadow register. It is applied when the
// run is armed, or on a period wrap while running, so a waveform period is
// never torn.
//
// Optional feature (compile-time macro AWG_BURST_EN):
//   defined   : cfg_burst port present; a nonzero burst count ends the run
//               after that many period wraps; zero means continuous.
//   undefined : no burst port or counter; generation runs until stop.
//
// Parameters
//   ACC_W    phase accumulator width (20..48)
//   BURST_W  burst counter width
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle run request (honoured in IDLE only)
//   stop            one-cycle request to finish at the next period boundary
//   cfg_valid/ready configuration handshake
//   cfg_freq/amp/phase [/burst]  configuration fields
//   en              generator enable (RUN or DRAIN)
//   cnt             registered phase index (0 while en=0)
//   state_freq/amp/phase  active configuration
//   wrap            one-cycle pulse after an accumulate that carried out
//   busy            sequencer not in IDLE
//   done            one-cycle pulse when a run returns to IDLE
//   fsm_state       current FSM state (IDLE=0, ARM=1, RUN=2, DRAIN=3)
// -----------------------------------------------------------------------------
module awg_seq_ctrl #(
  parameter int ACC_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [11:0]        cfg_freq,
  input  logic [2:0]         cfg_amp,
  input  logic [7:0]         cfg_phase,
`ifdef AWG_BURST_EN
  input  logic [BURST_W-1:0] cfg_burst,
`endif
  output logic               en,
  output logic [13:0]        cnt,
  output logic [11:0]        state_freq,
  output logic [2:0]         state_amp,
  output logic [7:0]         state_phase,
  output logic               wrap,
  output logic               busy,
  output logic               done,
  output logic [1:0]         fsm_state
);

  if (ACC_W < 20 || ACC_W > 48 || BURST_W < 1) begin : g_param_check
    $error("awg_seq_ctrl: ACC_W must be 20..48 and BURST_W at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n, step;
  logic [ACC_W:0]   sum;
  logic             carry, running, apply_cfg, finish;
  logic             pending;
  logic [11:0]      sh_freq;
  logic [2:0]       sh_amp;
  logic [7:0]       sh_phase;
  logic [7:0]       phase_n;
  logic [13:0]      cnt_n;
`ifdef AWG_BURST_EN
  logic [BURST_W-1:0] sh_burst, state_burst, burst_cnt, burst_cnt_n;
`endif

  assign running = (state == S_RUN) || (state == S_DRAIN);
  // The 12-bit step lands in the top 20 accumulator bits, so the frequency
  // resolution is independent of ACC_W.
  assign step    = {{(ACC_W-12){1'b0}}, state_freq} << (ACC_W - 20);
  assign sum     = {1'b0, acc} + {1'b0, step};
  assign carry   = sum[ACC_W];

  // Configuration handshake: a transfer happens on any cycle where
  // cfg_valid && cfg_ready. cfg_ready is simply !pending. Once a shadow is
  // pending, no further configuration is taken until that shadow is applied
  // (in ARM, or on a carry while in RUN).

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    apply_cfg = 1'b0;
    finish    = 1'b0;
`ifdef AWG_BURST_EN
    burst_cnt_n = burst_cnt;
`endif
    case (state)
      S_IDLE: begin
        acc_n = '0;
        if (start && !stop) state_n = S_ARM;
      end
      S_ARM: begin
        apply_cfg = pending;
        state_n   = S_RUN;
`ifdef AWG_BURST_EN
        burst_cnt_n = '0;
`endif
      end
      S_RUN: begin
        acc_n = sum[ACC_W-1:0];
        if (carry) apply_cfg = pending;
`ifdef AWG_BURST_EN
        if (carry) begin
          burst_cnt_n = burst_cnt + 1'b1;
          if ((state_burst != '0) && (burst_cnt_n == state_burst)) finish = 1'b1;
        end
`endif
        if (!finish && stop) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        acc_n = sum[ACC_W-1:0];
        // A zero step never carries, so DRAIN would otherwise never exit.
        if (carry || (state_freq == '0)) finish = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    if (finish) begin
      state_n = S_IDLE;
      acc_n   = '0;
    end
  end

  // cnt is registered from the next accumulator value and next phase, so it
  // tracks acc one pipeline stage downstream of the adder and reads 0 when
  // the next state is not generating.
  assign phase_n = apply_cfg ? sh_phase : state_phase;
  assign cnt_n   = ((state_n == S_RUN) || (state_n == S_DRAIN))
                   ? (acc_n[ACC_W-1 -: 14] + {phase_n, 6'b0}) : 14'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      wrap        <= 1'b0;
      done        <= 1'b0;
      pending     <= 1'b0;
      sh_freq     <= '0;
      sh_amp      <= '0;
      sh_phase    <= '0;
      state_freq  <= '0;
      state_amp   <= '0;
      state_phase <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      wrap  <= running && carry;
      done  <= finish;
      if (apply_cfg) begin
        state_freq  <= sh_freq;
        state_amp   <= sh_amp;
        state_phase <= sh_phase;
        pending     <= 1'b0;
      end else if (cfg_valid && !pending) begin
        sh_freq  <= cfg_freq;
        sh_amp   <= cfg_amp;
        sh_phase <= cfg_phase;
        pending  <= 1'b1;
      end
    end
  end

`ifdef AWG_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_burst    <= '0;
      state_burst <= '0;
      burst_cnt   <= '0;
    end else begin
      burst_cnt <= burst_cnt_n;
      if (apply_cfg) state_burst <= sh_burst;
      else if (cfg_valid && !pending) sh_burst <= cfg_burst;
    end
  end
`endif

  assign en        = running;
  assign busy      = (state != S_IDLE);
  assign cfg_ready = !pending;
  assign fsm_state = state;

endmodule

// File: tb/tb_awg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_awg_seq_ctrl
//
// Self-checking bench for awg_seq_ctrl at ACC_W=24. A per-cycle reference
// model of the accumulator, configuration shadow and run/drain sequencing
// predicts cnt/wrap/done/en. Each prediction is pushed into a queue when the
// cycle's stimulus is driven and popped after the clock edge. Build with
// +define+AWG_BURST_EN to also cover the burst feature.
// -----------------------------------------------------------------------------
module tb_awg_seq_ctrl;

  localparam int ACC_W   = 24;
  localparam int BURST_W = 16;
  localparam int SH      = ACC_W - 20;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [11:0]        cfg_freq = '0;
  logic [2:0]         cfg_amp = '0;
  logic [7:0]         cfg_phase = '0;
  logic [BURST_W-1:0] cfg_burst = '0;
  logic               cfg_ready, en, wrap, busy, done;
  logic [13:0]        cnt;
  logic [11:0]        state_freq;
  logic [2:0]         state_amp;
  logic [7:0]         state_phase;
  logic [1:0]         fsm_state;

  always #5 clk = ~clk;

  awg_seq_ctrl #(.ACC_W(ACC_W), .BURST_W(BURST_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_freq    (cfg_freq),
    .cfg_amp     (cfg_amp),
    .cfg_phase   (cfg_phase),
`ifdef AWG_BURST_EN
    .cfg_burst   (cfg_burst),
`endif
    .en          (en),
    .cnt         (cnt),
    .state_freq  (state_freq),
    .state_amp   (state_amp),
    .state_phase (state_phase),
    .wrap        (wrap),
    .busy        (busy),
    .done        (done),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int wrap_seen = 0;

  logic [13:0] exp_q[$];
  logic [2:0]  exp_flag_q[$];  // {wrap, done, en}

  logic [ACC_W-1:0]   m_acc;
  logic [11:0]        m_freq, m_sh_freq;
  logic [2:0]         m_amp, m_sh_amp;
  logic [7:0]         m_phase, m_sh_phase;
  logic [BURST_W-1:0] m_burst, m_sh_burst, m_bcnt;
  bit                 m_run, m_drain, m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] cnt_of(input logic [ACC_W-1:0] a, input logic [7:0] p);
    logic [13:0] top;
    top = a[ACC_W-1 -: 14];
    return top + {p, 6'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = '0; m_freq = '0; m_amp = '0; m_phase = '0; m_burst = '0;
    m_sh_freq = '0; m_sh_amp = '0; m_sh_phase = '0; m_sh_burst = '0;
    m_bcnt = '0; m_run = 0; m_drain = 0; m_pend = 0;
  endtask

  task automatic model_apply();
    m_freq = m_sh_freq; m_amp = m_sh_amp; m_phase = m_sh_phase;
    m_burst = m_sh_burst; m_pend = 0;
  endtask

  task automatic check_reset(input string t);
    check({t, "_en"}, en, 0);
    check({t, "_cnt"}, cnt, 0);
    check({t, "_wrap"}, wrap, 0);
    check({t, "_done"}, done, 0);
    check({t, "_busy"}, busy, 0);
    check({t, "_cfg_ready"}, cfg_ready, 1);
    check({t, "_freq"}, state_freq, 0);
    check({t, "_amp"}, state_amp, 0);
    check({t, "_phase"}, state_phase, 0);
    check({t, "_state"}, fsm_state, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cfg(input logic [11:0] f, input logic [2:0] a, input logic [7:0] p,
                          input logic [BURST_W-1:0] b);
    cfg_valid = 1; cfg_freq = f; cfg_amp = a; cfg_phase = p; cfg_burst = b;
    tick();
    cfg_valid = 0;
    if (!m_pend) begin
      m_pend = 1; m_sh_freq = f; m_sh_amp = a; m_sh_phase = p; m_sh_burst = b;
    end
    check("idle_cfg_ready", cfg_ready, !m_pend);
    check("idle_cfg_busy", busy, 0);
    check("idle_cfg_freq", state_freq, m_freq);
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
    check("arm_busy", busy, 1);
    check("arm_en", en, 0);
    check("arm_cnt", cnt, 0);
    check("arm_state", fsm_state, 1);
    tick();
    if (m_pend) model_apply();
    m_run = 1; m_drain = 0; m_acc = '0; m_bcnt = '0;
    check("run_state", fsm_state, 2);
    check("run_freq", state_freq, m_freq);
    check("run_amp", state_amp, m_amp);
    check("run_phase", state_phase, m_phase);
    check("run_cnt0", cnt, cnt_of(m_acc, m_phase));
    check("run_en", en, 1);
    check("run_cfg_ready", cfg_ready, !m_pend);
    check("run_wrap", wrap, 0);
  endtask

  // One clock of generation: drive, predict, push; then edge, pop, compare.
  task automatic step_cycle(input bit do_stop, input bit do_cfg,
                            input logic [11:0] f, input logic [7:0] p);
    logic [ACC_W:0] s;
    logic [13:0]    ec;
    logic [2:0]     ef;
    bit             carry, was_run, fin, take;
    stop = do_stop; cfg_valid = do_cfg; cfg_freq = f; cfg_amp = 3'd6; cfg_phase = p;
    s       = {1'b0, m_acc} + ({{(ACC_W-11){1'b0}}, m_freq} << SH);
    carry   = s[ACC_W];
    was_run = m_run;
    fin     = 0;
    take    = do_cfg && !m_pend;
    if (m_run) begin
      m_acc = s[ACC_W-1:0];
      if (!m_drain) begin
        if (carry && m_pend) model_apply();
        if (carry) begin
          m_bcnt = m_bcnt + 1'b1;
          if ((m_burst != 0) && (m_bcnt == m_burst)) fin = 1;
        end
        if (!fin && do_stop) m_drain = 1;
      end else if (carry || (m_freq == 0)) begin
        fin = 1;
      end
      if (fin) begin
        m_run = 0; m_drain = 0; m_acc = '0;
      end
    end
    if (take) begin
      m_pend = 1; m_sh_freq = f; m_sh_amp = 3'd6; m_sh_phase = p; m_sh_burst = cfg_burst;
    end
    ec = m_run ? cnt_of(m_acc, m_phase) : 14'd0;
    ef = {was_run && carry, fin, m_run};
    exp_q.push_back(ec);
    exp_flag_q.push_back(ef);
    tick();
    stop = 0; cfg_valid = 0;
    if (wrap) wrap_seen++;
    check("cnt", cnt, exp_q.pop_front());
    ef = exp_flag_q.pop_front();
    check("wrap", wrap, ef[2]);
    check("done", done, ef[1]);
    check("en", en, ef[0]);
    check("busy", busy, ef[0]);
    check("cfg_ready", cfg_ready, !m_pend);
    check("state_freq", state_freq, m_freq);
    check("state_phase", state_phase, m_phase);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    model_reset();

    // Reset values
    rst_n = 0;
    tick(); tick();
    check_reset("rst");
    rst_n = 1;
    tick();
    check_reset("post_rst");

    // Basic generation: freq 0x100, phase 0 -> cnt steps by 4, wrap every 4096
    idle_cfg(12'h100, 3'd5, 8'h00, '0);
    tick();
    check("idle_still_pending", cfg_ready, 0);
    check("idle_freq_unapplied", state_freq, 0);
    do_start();
    step_cycle(0, 0, '0, '0);
    check("step_4", cnt, 14'd4);
    step_cycle(0, 0, '0, '0);
    check("step_8", cnt, 14'd8);
    wrap_seen = 0;
    repeat (4098) step_cycle(0, 0, '0, '0);
    check("wrap_count_4100", wrap_seen, 1);

    // Mid-period reconfiguration takes effect only on the wrap
    repeat (1000) step_cycle(0, 0, '0, '0);
    step_cycle(0, 1, 12'h200, 8'h10);
    check("midcfg_ready_low", cfg_ready, 0);
    check("midcfg_freq_old", state_freq, 12'h100);
    wrap_seen = 0;
    for (int g = 0; g < 5000 && wrap_seen == 0; g++) step_cycle(0, 0, '0, '0);
    check("midcfg_wrap_seen", wrap_seen, 1);
    check("midcfg_ready_high", cfg_ready, 1);
    check("midcfg_freq_new", state_freq, 12'h200);
    check("midcfg_cnt_at_wrap", cnt, 14'h0400);
    step_cycle(0, 0, '0, '0);
    check("midcfg_step8", cnt, 14'h0408);

    // stop mid-period drains to the next carry
    repeat (300) step_cycle(0, 0, '0, '0);
    step_cycle(1, 0, '0, '0);
    check("drain_state", fsm_state, 3);
    check("drain_en", en, 1);
    for (int g = 0; g < 3000 && busy; g++) step_cycle(0, 0, '0, '0);
    check("drain_exit_busy", busy, 0);
    check("drain_exit_done", done, 1);
    check("drain_exit_cnt", cnt, 0);
    check("drain_exit_state", fsm_state, 0);
    step_cycle(0, 0, '0, '0);
    check("done_one_cycle", done, 0);

    // Phase offset 0x80 and start ignored while running
    idle_cfg(12'h100, 3'd2, 8'h80, '0);
    do_start();
    check("phase_first", cnt, 14'h2000);
    step_cycle(0, 0, '0, '0);
    check("phase_second", cnt, 14'h2004);
    start = 1;
    step_cycle(0, 0, '0, '0);
    start = 0;
    check("start_ignored", fsm_state, 2);
    repeat (50) step_cycle(0, 0, '0, '0);

    // Asynchronous reset mid-run: outputs fall without a clock edge
    #2;
    rst_n = 0;
    #1;
    check_reset("async_rst");
    tick(); tick();
    check("rst_no_done", done, 0);
    check_reset("rst_held");
    rst_n = 1;
    model_reset();
    tick();
    check_reset("rst_released");

    // start and stop together in IDLE: stay IDLE
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    check("ss_state", fsm_state, 0);
    check("ss_busy", busy, 0);
    tick();
    check("ss_state2", fsm_state, 0);
    check("ss_en", en, 0);

    // Zero frequency: DRAIN exits immediately
    idle_cfg(12'h000, 3'd1, 8'h40, '0);
    do_start();
    repeat (5) step_cycle(0, 0, '0, '0);
    check("f0_cnt_const", cnt, 14'h1000);
    step_cycle(1, 0, '0, '0);
    step_cycle(0, 0, '0, '0);
    check("f0_idle", busy, 0);
    check("f0_done", done, 1);

`ifdef AWG_BURST_EN
    begin : burst_test
      int run_cycles;
      idle_cfg(12'h100, 3'd3, 8'h00, 16'd3);
      wrap_seen = 0;
      do_start();
      run_cycles = 1;
      for (int g = 0; g < 13000 && busy; g++) begin
        step_cycle(0, 0, '0, '0);
        if (busy) run_cycles++;
      end
      check("burst_exit_busy", busy, 0);
      check("burst_wraps", wrap_seen, 3);
      check("burst_run_cycles", run_cycles, 12288);
      check("burst_done", done, 1);
      step_cycle(0, 0, '0, '0);
      check("burst_done_cleared", done, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
